// File: rtl/cheri_pkg.sv
// Shared types for the CHERI stack-zeroization LSU arbiter.
// Defines the arbiter FSM states and the owner tags stored per outstanding LSU transaction.
package cheri_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_STKZ = 2'd2
  } arb_state_t;

  localparam logic LSU_OWNER_CORE = 1'b0;
  localparam logic LSU_OWNER_STKZ = 1'b1;

endpackage

// File: rtl/cheri_owner_fifo.sv
// Owner-tag FIFO: one bit per issued LSU transaction, popped as in-order responses return.
// A push and a pop in the same cycle are legal, including when the FIFO is full.
module cheri_owner_fifo #(
  parameter int unsigned Depth = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic push_data_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [(2**AW)-1:0] mem_q;
  logic [AW-1:0]      wr_q, rd_q;
  logic [CW-1:0]      cnt_q;
  logic               do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(Depth));
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/cheri_stkz_lsu_arb.sv
// Shares the single LSU request port between the core load/store path and the stack zeroizer.
// Grants pass straight through to the LSU mux; responses are steered back using an owner-tag FIFO.
module cheri_stkz_lsu_arb
  import cheri_pkg::*;
#(
  parameter int unsigned DataWidth        = 33,
  parameter int unsigned MaxCoreBurst     = 4,
  parameter int unsigned OutstandingDepth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 core_req_i,
  input  logic                 core_we_i,
  input  logic                 core_is_cap_i,
  input  logic [31:0]          core_addr_i,
  input  logic [DataWidth-1:0] core_raw_wdata_i,
  output logic                 core_req_done_o,
  output logic                 core_resp_valid_o,
  output logic                 core_resp_err_o,
  input  logic                 stkz_req_i,
  input  logic                 stkz_we_i,
  input  logic                 stkz_is_cap_i,
  input  logic [31:0]          stkz_addr_i,
  input  logic [DataWidth-1:0] stkz_raw_wdata_i,
  input  logic                 stkz_abort_i,
  output logic                 lsu_stkz_req_done_o,
  output logic                 lsu_stkz_resp_valid_o,
  output logic                 lsu_stkz_resp_err_o,
  output logic                 lsu_req_o,
  output logic                 lsu_we_o,
  output logic                 lsu_is_cap_o,
  output logic [31:0]          lsu_addr_o,
  output logic [DataWidth-1:0] lsu_raw_wdata_o,
  input  logic                 lsu_req_done_i,
  input  logic                 lsu_resp_valid_i,
  input  logic                 lsu_resp_err_i,
  output logic                 arb_err_o
);

  arb_state_t state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       arb_err_q, arb_err_d;
  logic       gnt_core, gnt_stkz, accept, pop, can_issue;
  logic       fifo_full, fifo_empty, fifo_head;

  assign pop       = lsu_resp_valid_i && !fifo_empty;
  assign can_issue = !fifo_full || pop;

  // Owner states only re-check their own requester: a withdrawal drops the grant immediately.
  always_comb begin
    gnt_core = 1'b0;
    gnt_stkz = 1'b0;
    case (state_q)
      ARB_IDLE: if (can_issue) begin
        if (stkz_req_i && (stkz_abort_i || burst_q >= 4'(MaxCoreBurst) || !core_req_i))
          gnt_stkz = 1'b1;
        else if (core_req_i)
          gnt_core = 1'b1;
      end
      ARB_CORE: gnt_core = core_req_i;
      ARB_STKZ: gnt_stkz = stkz_req_i;
      default: ;
    endcase
  end

  assign accept = (gnt_core || gnt_stkz) && lsu_req_done_i;

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    arb_err_d = arb_err_q || (lsu_resp_valid_i && fifo_empty);
    case (state_q)
      ARB_IDLE: if (!lsu_req_done_i) begin
        if (gnt_stkz)      state_d = ARB_STKZ;
        else if (gnt_core) state_d = ARB_CORE;
      end
      ARB_CORE: if (!core_req_i || lsu_req_done_i) state_d = ARB_IDLE;
      ARB_STKZ: if (!stkz_req_i || lsu_req_done_i) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    if (!stkz_req_i || (accept && gnt_stkz))
      burst_d = '0;
    else if (accept && gnt_core && burst_q < 4'(MaxCoreBurst))
      burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_IDLE;
      burst_q   <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      arb_err_q <= arb_err_d;
    end
  end

  cheri_owner_fifo #(.Depth(OutstandingDepth)) u_owner_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (accept),
    .push_data_i (gnt_stkz ? LSU_OWNER_STKZ : LSU_OWNER_CORE),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign lsu_req_o       = gnt_core || gnt_stkz;
  assign lsu_we_o        = gnt_stkz ? stkz_we_i        : (gnt_core ? core_we_i        : 1'b0);
  assign lsu_is_cap_o    = gnt_stkz ? stkz_is_cap_i    : (gnt_core ? core_is_cap_i    : 1'b0);
  assign lsu_addr_o      = gnt_stkz ? stkz_addr_i      : (gnt_core ? core_addr_i      : '0);
  assign lsu_raw_wdata_o = gnt_stkz ? stkz_raw_wdata_i : (gnt_core ? core_raw_wdata_i : '0);

  assign core_req_done_o     = gnt_core && lsu_req_done_i;
  assign lsu_stkz_req_done_o = gnt_stkz && lsu_req_done_i;

  assign core_resp_valid_o     = pop && (fifo_head == LSU_OWNER_CORE);
  assign core_resp_err_o       = core_resp_valid_o && lsu_resp_err_i;
  assign lsu_stkz_resp_valid_o = pop && (fifo_head == LSU_OWNER_STKZ);
  assign lsu_stkz_resp_err_o   = lsu_stkz_resp_valid_o && lsu_resp_err_i;
  assign arb_err_o             = arb_err_q;

endmodule

// File: tb/tb_cheri_stkz_lsu_arb.sv
// Bench for cheri_stkz_lsu_arb: per-cycle vector table for grants, owner-tag scoreboard for responses,
// then a hand-written reset-mid-transaction sequence.
module tb_cheri_stkz_lsu_arb;

  localparam int DW = 33;
  localparam logic [31:0]   CORE_ADDR  = 32'h8000_0100;
  localparam logic [31:0]   STKZ_ADDR  = 32'h2000_0040;
  localparam logic [DW-1:0] CORE_WDATA = 33'h1_DEAD_BEEF;
  localparam logic [DW-1:0] STKZ_WDATA = 33'h0_0000_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic core_req, core_we, core_is_cap, stkz_req, stkz_we, stkz_is_cap, stkz_abort;
  logic [31:0] core_addr, stkz_addr, lsu_addr;
  logic [DW-1:0] core_wdata, stkz_wdata, lsu_wdata;
  logic core_done, core_rv, core_re, stkz_done, stkz_rv, stkz_re;
  logic lsu_req, lsu_we, lsu_is_cap, lsu_done, lsu_rv, lsu_re, arb_err;

  always #5 clk = ~clk;

  cheri_stkz_lsu_arb #(.DataWidth(DW), .MaxCoreBurst(4), .OutstandingDepth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_is_cap_i(core_is_cap),
    .core_addr_i(core_addr), .core_raw_wdata_i(core_wdata),
    .core_req_done_o(core_done), .core_resp_valid_o(core_rv), .core_resp_err_o(core_re),
    .stkz_req_i(stkz_req), .stkz_we_i(stkz_we), .stkz_is_cap_i(stkz_is_cap),
    .stkz_addr_i(stkz_addr), .stkz_raw_wdata_i(stkz_wdata), .stkz_abort_i(stkz_abort),
    .lsu_stkz_req_done_o(stkz_done), .lsu_stkz_resp_valid_o(stkz_rv), .lsu_stkz_resp_err_o(stkz_re),
    .lsu_req_o(lsu_req), .lsu_we_o(lsu_we), .lsu_is_cap_o(lsu_is_cap),
    .lsu_addr_o(lsu_addr), .lsu_raw_wdata_o(lsu_wdata),
    .lsu_req_done_i(lsu_done), .lsu_resp_valid_i(lsu_rv), .lsu_resp_err_i(lsu_re),
    .arb_err_o(arb_err)
  );

  // gnt: 0 none, 1 core, 2 stkz. aerr is the arb_err_o value seen before this cycle's edge.
  typedef struct packed {
    logic cr, sr, ab, dn, rv, re;
    logic [1:0] gnt;
    logic aerr;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];
  logic own_q[$];
  int checks = 0, failures = 0;

  function automatic vec_t mkv(input int cr, sr, ab, dn, rv, re, g, ae);
    vec_t v;
    v.cr = 1'(cr); v.sr = 1'(sr); v.ab = 1'(ab); v.dn = 1'(dn);
    v.rv = 1'(rv); v.re = 1'(re); v.gnt = 2'(g); v.aerr = 1'(ae);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    core_req = v.cr; stkz_req = v.sr; stkz_abort = v.ab;
    lsu_done = v.dn; lsu_rv = v.rv; lsu_re = v.re;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    logic [31:0] ea;
    logic [DW-1:0] ew;
    logic own, ecv, ece, esv, ese;
    ea = (v.gnt == 2'd1) ? CORE_ADDR  : (v.gnt == 2'd2) ? STKZ_ADDR  : 32'h0;
    ew = (v.gnt == 2'd1) ? CORE_WDATA : (v.gnt == 2'd2) ? STKZ_WDATA : '0;
    chk({tag, "_req"},   64'(lsu_req),    64'(v.gnt != 2'd0));
    chk({tag, "_addr"},  64'(lsu_addr),   64'(ea));
    chk({tag, "_wdata"}, 64'(lsu_wdata),  64'(ew));
    chk({tag, "_cap"},   64'(lsu_is_cap), 64'(v.gnt == 2'd2));
    chk({tag, "_cdone"}, 64'(core_done),  64'(v.gnt == 2'd1 && v.dn));
    chk({tag, "_sdone"}, 64'(stkz_done),  64'(v.gnt == 2'd2 && v.dn));
    chk({tag, "_aerr"},  64'(arb_err),    64'(v.aerr));
    ecv = 1'b0; ece = 1'b0; esv = 1'b0; ese = 1'b0;
    if (v.rv && own_q.size() > 0) begin
      own = own_q.pop_front();
      if (own) begin esv = 1'b1; ese = v.re; end
      else     begin ecv = 1'b1; ece = v.re; end
    end
    chk({tag, "_crv"}, 64'(core_rv), 64'(ecv));
    chk({tag, "_cre"}, 64'(core_re), 64'(ece));
    chk({tag, "_srv"}, 64'(stkz_rv), 64'(esv));
    chk({tag, "_sre"}, 64'(stkz_re), 64'(ese));
    if (v.gnt != 2'd0 && v.dn) own_q.push_back(v.gnt == 2'd2);
  endtask

  initial begin
    core_we = 1'b1; core_is_cap = 1'b0; core_addr = CORE_ADDR; core_wdata = CORE_WDATA;
    stkz_we = 1'b1; stkz_is_cap = 1'b1; stkz_addr = STKZ_ADDR; stkz_wdata = STKZ_WDATA;
    drive(mkv(0,0,0,0,0,0,0,0));

    //               cr sr ab dn rv re g ae
    vecs[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0); // idle after reset
    vecs[1]  = mkv(1, 0, 0, 1, 0, 0, 1, 0); // core only, done same cycle
    vecs[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mkv(0, 0, 0, 0, 1, 0, 0, 0); // core response
    vecs[4]  = mkv(1, 1, 0, 1, 0, 0, 1, 0); // burst: core x4, stkz x1
    vecs[5]  = mkv(1, 1, 0, 1, 1, 0, 1, 0);
    vecs[6]  = mkv(1, 1, 0, 1, 1, 0, 1, 0);
    vecs[7]  = mkv(1, 1, 0, 1, 1, 0, 1, 0);
    vecs[8]  = mkv(1, 1, 0, 1, 1, 0, 2, 0);
    vecs[9]  = mkv(1, 1, 0, 1, 1, 0, 1, 0);
    vecs[10] = mkv(0, 0, 0, 0, 1, 0, 0, 0);
    vecs[11] = mkv(1, 0, 0, 0, 0, 0, 1, 0); // ownership lock
    vecs[12] = mkv(1, 1, 0, 0, 0, 0, 1, 0);
    vecs[13] = mkv(1, 1, 0, 0, 0, 0, 1, 0);
    vecs[14] = mkv(1, 1, 0, 1, 0, 0, 1, 0);
    vecs[15] = mkv(0, 1, 0, 1, 0, 0, 2, 0);
    vecs[16] = mkv(0, 0, 0, 0, 1, 0, 0, 0); // interleaved responses
    vecs[17] = mkv(0, 0, 0, 0, 1, 1, 0, 0);
    vecs[18] = mkv(1, 1, 1, 1, 0, 0, 2, 0); // abort wins at burst 0
    vecs[19] = mkv(1, 0, 0, 1, 0, 0, 1, 0);
    vecs[20] = mkv(1, 0, 0, 1, 0, 0, 0, 0); // full, no pop
    vecs[21] = mkv(1, 0, 0, 1, 1, 0, 1, 0); // full with pop
    vecs[22] = mkv(0, 0, 0, 0, 1, 0, 0, 0);
    vecs[23] = mkv(0, 0, 0, 0, 1, 0, 0, 0);
    vecs[24] = mkv(0, 0, 0, 0, 1, 0, 0, 0); // spurious response
    vecs[25] = mkv(0, 0, 0, 0, 0, 0, 0, 1);
    vecs[26] = mkv(0, 1, 0, 0, 0, 0, 2, 1); // stkz withdraws
    vecs[27] = mkv(0, 0, 0, 0, 0, 0, 0, 1);
    vecs[28] = mkv(1, 0, 0, 1, 0, 0, 1, 1);
    vecs[29] = mkv(0, 0, 0, 0, 1, 1, 0, 1);

    repeat (3) @(posedge clk);
    #1 chk("reset_req", 64'(lsu_req), 64'(0));
    chk("reset_aerr", 64'(arb_err), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      #4;
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset with one transaction outstanding and core holding ownership.
    @(posedge clk); #1; drive(mkv(1,0,0,1,0,0,1,1)); #4; check_vec("mid_a", mkv(1,0,0,1,0,0,1,1));
    @(posedge clk); #1; drive(mkv(1,0,0,0,0,0,1,1)); #4; check_vec("mid_b", mkv(1,0,0,0,0,0,1,1));
    rst_n = 1'b0;
    drive(mkv(0,0,0,0,0,0,0,0));
    own_q.delete();
    #1;
    chk("rst_req",   64'(lsu_req),   64'(0));
    chk("rst_addr",  64'(lsu_addr),  64'(0));
    chk("rst_cdone", 64'(core_done), 64'(0));
    chk("rst_aerr",  64'(arb_err),   64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    // The FIFO must be empty: this response is dropped and flagged.
    @(posedge clk); #1; drive(mkv(0,0,0,0,1,0,0,0)); #4; check_vec("post_rst_rsp", mkv(0,0,0,0,1,0,0,0));
    @(posedge clk); #1; drive(mkv(0,0,0,0,0,0,0,1)); #4; check_vec("post_rst_err", mkv(0,0,0,0,0,0,0,1));
    // Fresh burst counter: contention goes to core first.
    @(posedge clk); #1; drive(mkv(1,1,0,0,0,0,1,1)); #4; check_vec("post_rst_gnt", mkv(1,1,0,0,0,0,1,1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
